sub_bytes_engine: RTL and testbench
===================================

# sub_bytes_engine

Parametrised AES SubBytes/InvSubBytes engine. It accepts one NBYTES-byte block per valid/ready handshake, with a per-block mode bit selecting forward or inverse S-box. The block is substituted over NBYTES/LANES beats using LANES physical S-box lanes, trading area for latency. It sits between the round-state register and ShiftRows/InvShiftRows in both the encrypt and decrypt datapaths, and replaces per-byte fixed-direction lookups.

## Interface
- NBYTES, 16: bytes per block. 4 is used for key expansion (word), 16 for round state.
- LANES, 4: S-box lanes instantiated. Must divide NBYTES, otherwise elaboration error.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input block present.
- in_ready  out  1  engine can accept a block this cycle.
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled only on accept.
- in_data  in  8*NBYTES  block; byte i = in_data[8i+7:8i].
- out_valid  out  1  substituted block available.
- out_ready  in  1  downstream accepts the output.
- out_data  out  8*NBYTES  substituted block, same byte ordering.

## Operation
- NBEATS = NBYTES/LANES. A beat counter of width max(1, clog2(NBEATS)) runs 0..NBEATS-1.
- FSM states:
  - IDLE
    - in_ready=1.
    - On in_valid: latch in_data into the block buffer, latch in_inv into the mode register, set beat=0, go to BUSY.
  - BUSY
    - in_ready=0.
    - Each cycle, buffer bytes [beat*LANES .. beat*LANES+LANES-1] are replaced by S(x) or S⁻¹(x) according to the latched mode. Increment beat.
    - On beat NBEATS-1: go to DONE and set out_valid=1.
  - DONE
    - out_valid=1; out_data = buffer.
    - On out_ready: drop out_valid and go to IDLE.
    - If in_valid is also high in that cycle, accept the new block in the same cycle and go directly to BUSY.
    - in_ready = out_ready in this state.
- Bytes not yet reached by the beat counter are never presented on out_data. out_data is driven from the buffer only; its value is don't-care when out_valid=0.
- in_inv and in_data are ignored whenever no handshake occurs.
- A mode change between blocks has no effect on the block in flight.
- Reset mid-operation (any state): the in-flight block is discarded. The FSM returns to IDLE, the buffer is cleared to 0, and no output is produced for the discarded block.
- Reset values: in_ready=1 once rst_n deasserts (0 while asserted), out_valid=0, out_data=0, beat=0, mode=0.

## Timing
- Accept edge = edge at which in_valid & in_ready. out_valid rises NBEATS edges after the accept edge (NBYTES=16, LANES=4 gives 4 cycles; LANES=NBYTES gives 1 cycle).
- Maximum throughput is one block per NBEATS+1 cycles, using the DONE-to-BUSY overlap.
- out_valid and out_data hold stable until the out_ready handshake, with no combinational path from in_* to out_*.
- The only combinational input-to-output path is out_ready → in_ready (in DONE).
- The S-box lookup is combinational within one beat. The buffer is the only pipeline register.

## Structure
- Shared package aes_pkg holds:
  - SBOX[256] and INV_SBOX[256] byte constant arrays.
  - An aes_byte_t typedef.
  - A function-free state enum sbe_state_t {IDLE, BUSY, DONE}.
- Sub-module aes_sbox_lane: one byte in, an inv select, one byte out, purely combinational table lookup from aes_pkg. Instantiated LANES times via generate.
- Lane k operates on buffer byte beat*LANES+k, selected by an indexed part-select.

## Test plan
- Forward, all-zero block (NBYTES=16, LANES=4) → out_data all bytes 0x63, out_valid 4 cycles after accept.
- Forward, bytes 0x00..0x0f (byte0=0x00) → 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76, in byte order.
- Inverse, all bytes 0x63 then byte0=0xed → output 0x00 everywhere with byte0=0x53. Then 1000 random blocks forward then inverse must round-trip exactly.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_data stable, in_ready=0. Raise out_ready with in_valid=1 → same-edge accept, next out_valid 4 cycles later.
- Reset asserted during beat 2 of BUSY → out_valid=0, in_ready=1 after release. No output for the aborted block; the next block processes correctly.
- Configs NBYTES=4/LANES=1 (latency 4) and NBYTES=16/LANES=16 (latency 1), forward 0x53 → 0xed in every byte.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES byte-substitution definitions: forward/inverse S-box tables,
// the byte type and the SubBytes engine state encoding.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sbe_state_t;

  // Element 0 is the leftmost entry, so SBOX[x] is the substitution of x.
  localparam aes_byte_t [0:255] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam aes_byte_t [0:255] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_lane.sv
// One physical S-box lane: combinational forward or inverse byte substitution.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  aes_byte_t in_byte,
  input  logic      inv,
  output aes_byte_t out_byte
);

  assign out_byte = inv ? INV_SBOX[in_byte] : SBOX[in_byte];

endmodule

// File: rtl/sub_bytes_engine.sv
// AES SubBytes/InvSubBytes engine: substitutes an NBYTES block in place over
// NBYTES/LANES beats, LANES bytes per beat, with a per-block direction bit.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_inv,
  input  logic [8*NBYTES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output sbe_state_t          dbg_state
);

  localparam int NBEATS = NBYTES / LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  if ((LANES < 1) || (NBYTES % LANES != 0)) begin : g_bad_cfg
    $error("sub_bytes_engine: LANES must divide NBYTES");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and in_ready only follows out_ready
  // while a finished block is waiting in DONE.

  sbe_state_t          state, state_nxt;
  logic [BW-1:0]       beat;
  logic                mode;
  logic [8*NBYTES-1:0] blk, blk_nxt;
  logic                accept;
  aes_byte_t           lane_in  [LANES];
  aes_byte_t           lane_out [LANES];

  assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = blk;
  assign dbg_state = state;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_in[k] = blk[(int'(beat) * LANES + k) * 8 +: 8];

    aes_sbox_lane u_lane (
      .in_byte  (lane_in[k]),
      .inv      (mode),
      .out_byte (lane_out[k])
    );
  end

  // Only the window of the current beat is rewritten; the rest of the block holds.
  always_comb begin
    blk_nxt = blk;
    for (int k = 0; k < LANES; k++) begin
      blk_nxt[(int'(beat) * LANES + k) * 8 +: 8] = lane_out[k];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (beat == LAST_BEAT) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk  <= '0;
      beat <= '0;
      mode <= 1'b0;
    end else if (accept) begin
      blk  <= in_data;
      mode <= in_inv;
      beat <= '0;
    end else if (state == BUSY) begin
      blk  <= blk_nxt;
      beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: scoreboard queue fed by the driver,
// monitor pops on each output handshake; also covers 4/1 and 16/16 configs.
module tb_sub_bytes_engine;
  import aes_pkg::*;

  localparam int W = 128;
  localparam int NBEATS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic         in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  sbe_state_t   dbg_state;

  logic        v4 = 1'b0, r4, ov4;
  logic [31:0] d4 = '0, q4;
  sbe_state_t  s4;
  logic         v16 = 1'b0, r16, ov16;
  logic [W-1:0] d16 = '0, q16;
  sbe_state_t   s16;

  logic [W-1:0] exp_q [$];
  bit           chk_q [$];
  int           lat_q [$];
  logic [W-1:0] got_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_engine #(.NBYTES(16), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dbg_state(dbg_state)
  );

  sub_bytes_engine #(.NBYTES(4), .LANES(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_inv(1'b0),
    .in_data(d4), .out_valid(ov4), .out_ready(1'b1), .out_data(q4), .dbg_state(s4)
  );

  sub_bytes_engine #(.NBYTES(16), .LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .in_inv(1'b0),
    .in_data(d16), .out_valid(ov16), .out_ready(1'b1), .out_data(q16), .dbg_state(s16)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Caller is at a negedge; returns #1 after the accepting posedge.
  task automatic send_block(input logic [W-1:0] d, input logic inv, input logic [W-1:0] e, input bit c);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    lat_q.push_back(cyc);
    exp_q.push_back(e);
    chk_q.push_back(c);
    in_valid = 1'b0;
    in_inv   = 1'($urandom_range(0, 1));
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  // Monitor: latency on each out_valid rise, data on each output handshake.
  initial begin
    logic prev_v = 1'b0;
    logic [W-1:0] e;
    bit c;
    int a;
    forever begin
      @(negedge clk); #2;
      if (out_valid && !prev_v) begin
        if (lat_q.size() == 0) fail_now("spurious_valid");
        else begin
          a = lat_q.pop_front();
          check("latency", W'(cyc - a), W'(NBEATS));
        end
      end
      prev_v = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else begin
          e = exp_q.pop_front();
          c = chk_q.pop_front();
          if (c) check("out_data", out_data, e);
          else got_q.push_back(out_data);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x, y;
    int a;
    bit seen;

    // Reset
    repeat (3) @(negedge clk);
    #1;
    check("ready_in_reset", W'(in_ready), W'(0));
    check("valid_in_reset", W'(out_valid), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", W'(in_ready), W'(1));
    check("data_after_reset", out_data, '0);
    check("state_after_reset", W'(dbg_state), W'(IDLE));

    // Directed vectors
    @(negedge clk); send_block('0, 1'b0, {16{8'h63}}, 1'b1);
    drain();
    @(negedge clk); send_block(128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                               128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1);
    drain();
    @(negedge clk); send_block({{15{8'h63}}, 8'hed}, 1'b1, {{15{8'h00}}, 8'h53}, 1'b1);
    drain();

    // Backpressure, then same-edge accept out of DONE
    out_ready = 1'b0;
    @(negedge clk); send_block(128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                               128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk); #2;
      check("bp_hold_data", out_data, 128'h76abd7fe2b670130c56f6bf27b777c63);
      check("bp_hold_valid", W'(out_valid), W'(1));
      check("bp_ready_low", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    send_block({16{8'h53}}, 1'b0, {16{8'hed}}, 1'b1);
    check("overlap_to_busy", W'(dbg_state), W'(BUSY));
    drain();

    // Reset during beat 2
    @(negedge clk); send_block({16{8'h11}}, 1'b0, {16{8'h82}}, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete(); chk_q.delete(); lat_q.delete();
    #1;
    check("abort_valid", W'(out_valid), W'(0));
    check("abort_ready", W'(in_ready), W'(0));
    check("abort_state", W'(dbg_state), W'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready_release", W'(in_ready), W'(1));
    check("abort_data_cleared", out_data, '0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk); #2;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_output", W'(seen), W'(0));
    @(negedge clk); send_block(128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                               128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1);
    drain();

    // Random forward/inverse round-trip
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk); send_block(x, 1'b0, '0, 1'b0);
      for (int n = 0; n < 50 && got_q.size() == 0; n++) @(negedge clk);
      if (got_q.size() == 0) begin
        fail_now("roundtrip_timeout");
        break;
      end
      y = got_q.pop_front();
      send_block(y, 1'b1, x, 1'b1);
    end
    drain();

    // NBYTES=4, LANES=1
    @(negedge clk);
    v4 = 1'b1; d4 = {4{8'h53}};
    #1 check("cfg4_ready", W'(r4), W'(1));
    @(posedge clk); #1;
    a = cyc; v4 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #2;
      if (ov4) break;
    end
    check("cfg4_latency", W'(cyc - a), W'(4));
    check("cfg4_data", W'(q4), W'({4{8'hed}}));

    // NBYTES=16, LANES=16
    @(negedge clk);
    v16 = 1'b1; d16 = {16{8'h53}};
    #1 check("cfg16_ready", W'(r16), W'(1));
    @(posedge clk); #1;
    a = cyc; v16 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #2;
      if (ov16) break;
    end
    check("cfg16_latency", W'(cyc - a), W'(1));
    check("cfg16_data", q16, {16{8'hed}});

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
